// File: rtl/mem_stage_if.sv
// Bus bundle between execute, the memory stage, the data memory and the register file.
// The slave modport is the memory stage's view; the master modport is the surrounding pipeline/memory.
interface mem_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  // ixmem bus from execute
  logic              inst_valid_ixmem_p1;
  logic [DATA_W-1:0] dest_reg_value_ixmem_p1;
  logic [2:0]        dest_reg_index_ixmem_p1;
  logic              dest_reg_write_valid_ixmem_p1;
  logic [ADDR_W-1:0] mem_addr_ixmem_p1;
  logic              ldst_valid_ixmem_p1;
  logic [1:0]        store_valid_ixmem_p1;
  logic [DATA_W-1:0] mem_data_in_ixmem_p1;

  // data memory request / response
  logic              mem_req_p1;
  logic              mem_we_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic              mem_ready_p1;
  logic              mem_rsp_valid_p1;
  logic [DATA_W-1:0] mem_rdata_p1;

  // pipeline control, writeback and error
  logic              stall_mem_p1;
  logic [DATA_W-1:0] wb_value_memwb_p1;
  logic [2:0]        wb_index_memwb_p1;
  logic              wb_valid_memwb_p1;
  logic              err_misalign_p1;

  modport slave (
    input  inst_valid_ixmem_p1,
    input  dest_reg_value_ixmem_p1,
    input  dest_reg_index_ixmem_p1,
    input  dest_reg_write_valid_ixmem_p1,
    input  mem_addr_ixmem_p1,
    input  ldst_valid_ixmem_p1,
    input  store_valid_ixmem_p1,
    input  mem_data_in_ixmem_p1,
    output mem_req_p1,
    output mem_we_p1,
    output mem_addr_p1,
    output mem_wdata_p1,
    input  mem_ready_p1,
    input  mem_rsp_valid_p1,
    input  mem_rdata_p1,
    output stall_mem_p1,
    output wb_value_memwb_p1,
    output wb_index_memwb_p1,
    output wb_valid_memwb_p1,
    output err_misalign_p1
  );

  modport master (
    output inst_valid_ixmem_p1,
    output dest_reg_value_ixmem_p1,
    output dest_reg_index_ixmem_p1,
    output dest_reg_write_valid_ixmem_p1,
    output mem_addr_ixmem_p1,
    output ldst_valid_ixmem_p1,
    output store_valid_ixmem_p1,
    output mem_data_in_ixmem_p1,
    input  mem_req_p1,
    input  mem_we_p1,
    input  mem_addr_p1,
    input  mem_wdata_p1,
    output mem_ready_p1,
    output mem_rsp_valid_p1,
    output mem_rdata_p1,
    input  stall_mem_p1,
    input  wb_value_memwb_p1,
    input  wb_index_memwb_p1,
    input  wb_valid_memwb_p1,
    input  err_misalign_p1
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns ixmem instructions into data-memory requests and
// produces the registered memwb writeback bus, stalling execute while an access is in flight.
module mem_stage #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Request fields captured at accept; upstream may change the bus once we leave IDLE.
  logic [ADDR_W-1:0] req_addr,  req_addr_nxt;
  logic [DATA_W-1:0] req_wdata, req_wdata_nxt;
  logic              req_we,    req_we_nxt;
  logic              req_upd,   req_upd_nxt;
  logic [2:0]        req_index, req_index_nxt;

  logic [DATA_W-1:0] wb_value,  wb_value_nxt;
  logic [2:0]        wb_index,  wb_index_nxt;
  logic              wb_valid,  wb_valid_nxt;
  logic              err_misalign, err_misalign_nxt;

  logic accept;
  logic misaligned;
  logic in_req;

  assign accept     = (state == S_IDLE) && bus.inst_valid_ixmem_p1;
  assign misaligned = (CHECK_ALIGN != 0) && bus.mem_addr_ixmem_p1[0];
  assign in_req     = (state == S_REQ);

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch; the case arms only override what changes.
  always_comb begin
    state_nxt        = state;
    req_addr_nxt     = req_addr;
    req_wdata_nxt    = req_wdata;
    req_we_nxt       = req_we;
    req_upd_nxt      = req_upd;
    req_index_nxt    = req_index;
    wb_valid_nxt     = 1'b0;
    wb_value_nxt     = wb_value;
    wb_index_nxt     = wb_index;
    err_misalign_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!bus.ldst_valid_ixmem_p1) begin
            // Non-memory op retires in one cycle; the value only moves when it is written.
            wb_valid_nxt = bus.dest_reg_write_valid_ixmem_p1;
            if (bus.dest_reg_write_valid_ixmem_p1) begin
              wb_value_nxt = bus.dest_reg_value_ixmem_p1;
              wb_index_nxt = bus.dest_reg_index_ixmem_p1;
            end
          end else if (misaligned) begin
            err_misalign_nxt = 1'b1;
          end else begin
            req_addr_nxt  = bus.mem_addr_ixmem_p1;
            req_wdata_nxt = bus.mem_data_in_ixmem_p1;
            req_we_nxt    = bus.store_valid_ixmem_p1[0];
            req_upd_nxt   = bus.store_valid_ixmem_p1[1];
            req_index_nxt = bus.dest_reg_index_ixmem_p1;
            state_nxt     = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (bus.mem_ready_p1) begin
          if (req_we) begin
            state_nxt = S_IDLE;
            // Store-with-update writes the effective address back to the base register.
            if (req_upd) begin
              wb_valid_nxt = 1'b1;
              wb_value_nxt = DATA_W'(req_addr);
              wb_index_nxt = req_index;
            end
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (bus.mem_rsp_valid_p1) begin
          wb_valid_nxt = 1'b1;
          wb_value_nxt = bus.mem_rdata_p1;
          wb_index_nxt = req_index;
          state_nxt    = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset abandons any outstanding access; returning to IDLE makes a late response inert.
      state        <= S_IDLE;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_we       <= 1'b0;
      req_upd      <= 1'b0;
      req_index    <= '0;
      wb_valid     <= 1'b0;
      wb_value     <= '0;
      wb_index     <= '0;
      err_misalign <= 1'b0;
    end else begin
      state        <= state_nxt;
      req_addr     <= req_addr_nxt;
      req_wdata    <= req_wdata_nxt;
      req_we       <= req_we_nxt;
      req_upd      <= req_upd_nxt;
      req_index    <= req_index_nxt;
      wb_valid     <= wb_valid_nxt;
      wb_value     <= wb_value_nxt;
      wb_index     <= wb_index_nxt;
      err_misalign <= err_misalign_nxt;
    end
  end

  // Request outputs are decoded from registered state and forced to zero outside REQ.
  assign bus.mem_req_p1   = in_req;
  assign bus.mem_we_p1    = in_req & req_we;
  assign bus.mem_addr_p1  = in_req ? req_addr  : '0;
  assign bus.mem_wdata_p1 = in_req ? req_wdata : '0;

  assign bus.stall_mem_p1      = (state != S_IDLE);
  assign bus.wb_value_memwb_p1 = wb_value;
  assign bus.wb_index_memwb_p1 = wb_index;
  assign bus.wb_valid_memwb_p1 = wb_valid;
  assign bus.err_misalign_p1   = err_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: writebacks are scoreboarded in issue order, control and
// request outputs are checked at each step on the falling clock edge.
module tb_mem_stage;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [2:0]        index;
  } wb_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  wb_t  sb_q[$];

  mem_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHECK_ALIGN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.inst_valid_ixmem_p1           = 1'b0;
    bus.dest_reg_value_ixmem_p1       = '0;
    bus.dest_reg_index_ixmem_p1       = '0;
    bus.dest_reg_write_valid_ixmem_p1 = 1'b0;
    bus.mem_addr_ixmem_p1             = '0;
    bus.ldst_valid_ixmem_p1           = 1'b0;
    bus.store_valid_ixmem_p1          = '0;
    bus.mem_data_in_ixmem_p1          = '0;
  endtask

  task automatic drive_op(input logic ldst, input logic [1:0] sv, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] value,
                          input logic [2:0] idx, input logic wv);
    bus.inst_valid_ixmem_p1           = 1'b1;
    bus.ldst_valid_ixmem_p1           = ldst;
    bus.store_valid_ixmem_p1          = sv;
    bus.mem_addr_ixmem_p1             = addr;
    bus.mem_data_in_ixmem_p1          = wdata;
    bus.dest_reg_value_ixmem_p1       = value;
    bus.dest_reg_index_ixmem_p1       = idx;
    bus.dest_reg_write_valid_ixmem_p1 = wv;
  endtask

  task automatic push_wb(input logic [15:0] value, input logic [2:0] idx);
    wb_t e;
    e.value = value;
    e.index = idx;
    sb_q.push_back(e);
  endtask

  // Writeback monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.wb_valid_memwb_p1 === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_value", 32'(bus.wb_value_memwb_p1), 32'(e.value));
        check("wb_index", 32'(bus.wb_index_memwb_p1), 32'(e.index));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_bus();
    bus.mem_ready_p1     = 1'b0;
    bus.mem_rsp_valid_p1 = 1'b0;
    bus.mem_rdata_p1     = '0;
    step();
    step();
    check("rst_stall",   32'(bus.stall_mem_p1),      32'd0);
    check("rst_req",     32'(bus.mem_req_p1),        32'd0);
    check("rst_wbvalid", 32'(bus.wb_valid_memwb_p1), 32'd0);
    check("rst_wbvalue", 32'(bus.wb_value_memwb_p1), 32'd0);
    check("rst_err",     32'(bus.err_misalign_p1),   32'd0);
    rst = 1'b0;

    // ALU op, latency 1
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 3'd5, 1'b1);
    push_wb(16'h1234, 3'd5);
    step();
    idle_bus();
    check("alu_stall", 32'(bus.stall_mem_p1), 32'd0);
    check("alu_wbv",   32'(bus.wb_valid_memwb_p1), 32'd1);
    step();
    check("alu_pulse", 32'(bus.wb_valid_memwb_p1), 32'd0);
    check("alu_hold",  32'(bus.wb_value_memwb_p1), 32'h1234);

    // Back-to-back ALU ops, then one that does not write
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 3'd1, 1'b1);
    push_wb(16'h1111, 3'd1);
    step();
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h2222, 3'd2, 1'b1);
    push_wb(16'h2222, 3'd2);
    step();
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h3333, 3'd7, 1'b0);
    step();
    idle_bus();
    check("nowr_wbv",  32'(bus.wb_valid_memwb_p1), 32'd0);
    check("nowr_hold", 32'(bus.wb_value_memwb_p1), 32'h2222);

    // Stray response in IDLE is ignored
    bus.mem_rsp_valid_p1 = 1'b1;
    bus.mem_rdata_p1     = 16'hDEAD;
    step();
    bus.mem_rsp_valid_p1 = 1'b0;
    step();
    check("stray_rsp", 32'(bus.wb_valid_memwb_p1), 32'd0);

    // Load with two wait states on ready, response two cycles after acceptance
    drive_op(1'b1, 2'b00, 16'h0040, 16'h0000, 16'h0000, 3'd2, 1'b1);
    step();
    idle_bus();
    check("ld_req0",   32'(bus.mem_req_p1),   32'd1);
    check("ld_we0",    32'(bus.mem_we_p1),    32'd0);
    check("ld_addr0",  32'(bus.mem_addr_p1),  32'h0040);
    check("ld_stall0", 32'(bus.stall_mem_p1), 32'd1);
    step();
    check("ld_req1",   32'(bus.mem_req_p1),   32'd1);
    check("ld_addr1",  32'(bus.mem_addr_p1),  32'h0040);
    step();
    check("ld_req2",   32'(bus.mem_req_p1),   32'd1);
    bus.mem_ready_p1 = 1'b1;
    step();
    bus.mem_ready_p1 = 1'b0;
    check("ld_wait_req",  32'(bus.mem_req_p1),   32'd0);
    check("ld_wait_addr", 32'(bus.mem_addr_p1),  32'h0000);
    check("ld_wait_stl",  32'(bus.stall_mem_p1), 32'd1);
    step();
    check("ld_wait_stl2", 32'(bus.stall_mem_p1), 32'd1);
    bus.mem_rsp_valid_p1 = 1'b1;
    bus.mem_rdata_p1     = 16'hBEEF;
    push_wb(16'hBEEF, 3'd2);
    step();
    bus.mem_rsp_valid_p1 = 1'b0;
    check("ld_done_stl", 32'(bus.stall_mem_p1), 32'd0);
    check("ld_done_wbv", 32'(bus.wb_valid_memwb_p1), 32'd1);
    step();

    // Store-with-update, zero-wait memory
    drive_op(1'b1, 2'b11, 16'h0102, 16'hA5A5, 16'h0000, 3'd3, 1'b1);
    step();
    idle_bus();
    check("st_req",   32'(bus.mem_req_p1),   32'd1);
    check("st_we",    32'(bus.mem_we_p1),    32'd1);
    check("st_addr",  32'(bus.mem_addr_p1),  32'h0102);
    check("st_wdata", 32'(bus.mem_wdata_p1), 32'hA5A5);
    bus.mem_ready_p1 = 1'b1;
    push_wb(16'h0102, 3'd3);
    step();
    bus.mem_ready_p1 = 1'b0;
    check("st_stall", 32'(bus.stall_mem_p1), 32'd0);
    check("st_wbv",   32'(bus.wb_valid_memwb_p1), 32'd1);
    check("st_req_off", 32'(bus.mem_req_p1), 32'd0);

    // Plain store: no writeback
    drive_op(1'b1, 2'b01, 16'h0200, 16'h5A5A, 16'h0000, 3'd4, 1'b0);
    step();
    idle_bus();
    check("pst_wdata", 32'(bus.mem_wdata_p1), 32'h5A5A);
    bus.mem_ready_p1 = 1'b1;
    step();
    bus.mem_ready_p1 = 1'b0;
    check("pst_wbv",   32'(bus.wb_valid_memwb_p1), 32'd0);
    check("pst_stall", 32'(bus.stall_mem_p1), 32'd0);

    // Misaligned load, then an ALU op accepted the very next cycle
    drive_op(1'b1, 2'b00, 16'h0103, 16'h0000, 16'h0000, 3'd1, 1'b1);
    step();
    check("mis_err",   32'(bus.err_misalign_p1),   32'd1);
    check("mis_req",   32'(bus.mem_req_p1),        32'd0);
    check("mis_stall", 32'(bus.stall_mem_p1),      32'd0);
    check("mis_wbv",   32'(bus.wb_valid_memwb_p1), 32'd0);
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h7777, 3'd6, 1'b1);
    push_wb(16'h7777, 3'd6);
    step();
    idle_bus();
    check("mis_err_pulse", 32'(bus.err_misalign_p1), 32'd0);
    check("mis_req2",      32'(bus.mem_req_p1),      32'd0);
    check("mis_alu_wbv",   32'(bus.wb_valid_memwb_p1), 32'd1);
    step();

    // Load followed by an ALU op held on the bus during the stall
    drive_op(1'b1, 2'b00, 16'h0300, 16'h0000, 16'h0000, 3'd1, 1'b1);
    step();
    drive_op(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h5555, 3'd4, 1'b1);
    check("b2b_stall", 32'(bus.stall_mem_p1), 32'd1);
    check("b2b_req",   32'(bus.mem_req_p1),   32'd1);
    bus.mem_ready_p1 = 1'b1;
    step();
    bus.mem_ready_p1 = 1'b0;
    check("b2b_wait_wbv", 32'(bus.wb_valid_memwb_p1), 32'd0);
    bus.mem_rsp_valid_p1 = 1'b1;
    bus.mem_rdata_p1     = 16'h1111;
    push_wb(16'h1111, 3'd1);
    step();
    bus.mem_rsp_valid_p1 = 1'b0;
    check("b2b_idle", 32'(bus.stall_mem_p1), 32'd0);
    push_wb(16'h5555, 3'd4);
    step();
    idle_bus();
    check("b2b_alu_stall", 32'(bus.stall_mem_p1), 32'd0);
    step();
    check("b2b_quiet", 32'(bus.wb_valid_memwb_p1), 32'd0);

    // Reset while waiting for a load response; the late response must be ignored
    drive_op(1'b1, 2'b00, 16'h0044, 16'h0000, 16'h0000, 3'd7, 1'b1);
    step();
    idle_bus();
    bus.mem_ready_p1 = 1'b1;
    step();
    bus.mem_ready_p1 = 1'b0;
    check("rl_wait_stall", 32'(bus.stall_mem_p1), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rl_stall",   32'(bus.stall_mem_p1),      32'd0);
    check("rl_req",     32'(bus.mem_req_p1),        32'd0);
    check("rl_wbvalid", 32'(bus.wb_valid_memwb_p1), 32'd0);
    check("rl_wbvalue", 32'(bus.wb_value_memwb_p1), 32'd0);
    check("rl_wbindex", 32'(bus.wb_index_memwb_p1), 32'd0);
    check("rl_err",     32'(bus.err_misalign_p1),   32'd0);
    bus.mem_rsp_valid_p1 = 1'b1;
    bus.mem_rdata_p1     = 16'hBEEF;
    step();
    bus.mem_rsp_valid_p1 = 1'b0;
    check("rl_late_wbv",   32'(bus.wb_valid_memwb_p1), 32'd0);
    check("rl_late_value", 32'(bus.wb_value_memwb_p1), 32'd0);
    check("rl_late_stall", 32'(bus.stall_mem_p1),      32'd0);
    step();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
